// File: rtl/plic_device.sv
// PLIC for hart 0: level gateways, per-context priority arbitration, claim/complete over MMIO.
// Reads answer exactly 1 cycle later, and eip outputs are registered; there is no backpressure because one request per cycle is always accepted.
package plic_pkg;
   typedef struct packed {
      logic        valid;
      logic [7:0]  id;
      logic [31:0] paddr;
      logic        is_write;
      logic [31:0] data;
   } device_req_t;

   typedef struct packed {
      logic        valid;
      logic [7:0]  id;
      logic [31:0] data;
   } device_res_t;
endpackage

module plic_device
   import plic_pkg::*;
#(
   parameter int          NUM_SOURCES = 32,
   parameter int          PRIO_WIDTH  = 3,
   parameter logic [31:0] PLIC_BASE   = 32'h0C00_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  device_req_t            req_in,
   output device_res_t            res_out,
   input  logic [NUM_SOURCES-1:0] src_irq,
   output logic                   meip,
   output logic                   seip
);
   localparam int N   = NUM_SOURCES;
   localparam int W   = PRIO_WIDTH;
   localparam int IDW = $clog2(N);

   logic [W-1:0]   prio [N];
   logic [N-1:0]   pending, in_flight, en0, en1;
   logic [N-1:0]   pend_n, infl_n;
   logic [W-1:0]   thr0, thr1, bp0, bp1;
   logic [IDW-1:0] best0, best1, prio_idx, cmp_idx;
   logic [31:0]    off, wdat, rdata;
   logic           is_prio, is_pend, is_en0, is_en1, is_thr0, is_thr1, is_clm0, is_clm1;
   logic           addr_ok, rd, wr, claim0, claim1, cmp_ok;

   assign off      = req_in.paddr - PLIC_BASE;
   assign wdat     = req_in.data;
   assign prio_idx = off[IDW+1:2];
   assign cmp_idx  = wdat[IDW-1:0];

   assign is_prio = (off[1:0] == 2'b00) && (off[31:2] != 30'd0) && (off[31:2] < 30'(N));
   assign is_pend = (off == 32'h0000_1000);
   assign is_en0  = (off == 32'h0000_2000);
   assign is_en1  = (off == 32'h0000_2080);
   assign is_thr0 = (off == 32'h0020_0000);
   assign is_clm0 = (off == 32'h0020_0004);
   assign is_thr1 = (off == 32'h0020_1000);
   assign is_clm1 = (off == 32'h0020_1004);
   assign addr_ok = is_prio | is_pend | is_en0 | is_en1 | is_thr0 | is_thr1 | is_clm0 | is_clm1;

   assign rd = req_in.valid & ~req_in.is_write;
   assign wr = req_in.valid &  req_in.is_write;

   // Strict '>' against the running best keeps the lowest ID on priority ties.
   always_comb begin
      best0 = '0;
      best1 = '0;
      bp0   = thr0;
      bp1   = thr1;
      for (int i = 1; i < N; i++) begin
         if (pending[i] && en0[i] && (prio[i] > bp0)) begin
            best0 = IDW'(i);
            bp0   = prio[i];
         end
         if (pending[i] && en1[i] && (prio[i] > bp1)) begin
            best1 = IDW'(i);
            bp1   = prio[i];
         end
      end
   end

   assign claim0 = rd && is_clm0 && (best0 != '0);
   assign claim1 = rd && is_clm1 && (best1 != '0);
   assign cmp_ok = wr && (is_clm0 || is_clm1) && (wdat != 32'd0) && (wdat < 32'(N));

   always_comb begin
      rdata = '0;
      if (is_prio)      rdata = 32'(prio[prio_idx]);
      else if (is_pend) rdata = 32'(pending);
      else if (is_en0)  rdata = 32'(en0);
      else if (is_en1)  rdata = 32'(en1);
      else if (is_thr0) rdata = 32'(thr0);
      else if (is_thr1) rdata = 32'(thr1);
      else if (is_clm0) rdata = 32'(best0);
      else if (is_clm1) rdata = 32'(best1);
   end

   // Gateway uses the pre-edge in_flight, so a completion re-arms pending one edge later;
   // a same-edge claim overrides the gateway set.
   always_comb begin
      pend_n    = pending | (src_irq & ~in_flight);
      pend_n[0] = 1'b0;
      infl_n    = in_flight;
      if (claim0) begin
         pend_n[best0] = 1'b0;
         infl_n[best0] = 1'b1;
      end
      if (claim1) begin
         pend_n[best1] = 1'b0;
         infl_n[best1] = 1'b1;
      end
      if (cmp_ok && in_flight[cmp_idx]) infl_n[cmp_idx] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) prio[i] <= '0;
         pending   <= '0;
         in_flight <= '0;
         en0       <= '0;
         en1       <= '0;
         thr0      <= '0;
         thr1      <= '0;
         res_out   <= '0;
         meip      <= 1'b0;
         seip      <= 1'b0;
      end else begin
         pending   <= pend_n;
         in_flight <= infl_n;
         meip      <= (best0 != '0);
         seip      <= (best1 != '0);
         if (rd) res_out <= '{valid: 1'b1, id: req_in.id, data: rdata};
         else    res_out <= '0;
         if (wr) begin
            if (is_prio) prio[prio_idx] <= wdat[W-1:0];
            if (is_en0)  en0  <= {wdat[N-1:1], 1'b0};
            if (is_en1)  en1  <= {wdat[N-1:1], 1'b0};
            if (is_thr0) thr0 <= wdat[W-1:0];
            if (is_thr1) thr1 <= wdat[W-1:0];
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!reset && req_in.valid && !addr_ok) $display("[ERROR] [plic_device.sv] invalid req");
   end
`endif
endmodule

// File: tb/tb_plic_device.sv
// Randomized + directed bench for plic_device against an array-based reference model.
module tb_plic_device;
   import plic_pkg::*;

   localparam int          N    = 24;
   localparam logic [31:0] BASE = 32'h0C00_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   device_req_t req_in;
   device_res_t res_out;
   logic [N-1:0] src_irq;
   logic        meip, seip;

   plic_device #(.NUM_SOURCES(N), .PRIO_WIDTH(3), .PLIC_BASE(BASE)) dut (
      .clock(clock), .reset(reset), .req_in(req_in), .res_out(res_out),
      .src_irq(src_irq), .meip(meip), .seip(seip)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_prio [N];
   bit          m_pend [N];
   bit          m_infl [N];
   bit          m_en   [2][N];
   int          m_thr  [2];
   bit          e_meip, e_seip;
   device_res_t e_res;

   // Highest eligible priority first, then the smallest ID holding it.
   function automatic int m_best(int c);
      int top = -1;
      for (int i = 1; i < N; i++)
         if (m_pend[i] && m_en[c][i] && m_prio[i] > m_thr[c] && m_prio[i] > top) top = m_prio[i];
      if (top < 0) return 0;
      for (int i = 1; i < N; i++)
         if (m_pend[i] && m_en[c][i] && m_prio[i] == top) return i;
      return 0;
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] off, int b0, int b1);
      logic [31:0] r = '0;
      if (off[1:0] == 2'b00 && off >= 32'd4 && off < 32'(4 * N)) r = 32'(m_prio[off >> 2]);
      else if (off == 32'h1000) for (int i = 0; i < N; i++) r[i] = m_pend[i];
      else if (off == 32'h2000) for (int i = 0; i < N; i++) r[i] = m_en[0][i];
      else if (off == 32'h2080) for (int i = 0; i < N; i++) r[i] = m_en[1][i];
      else if (off == 32'h20_0000) r = 32'(m_thr[0]);
      else if (off == 32'h20_1000) r = 32'(m_thr[1]);
      else if (off == 32'h20_0004) r = 32'(b0);
      else if (off == 32'h20_1004) r = 32'(b1);
      return r;
   endfunction

   always @(posedge clock or posedge reset) begin : mdl
      int          b0, b1, c;
      bit          np [N];
      bit          ni [N];
      logic [31:0] off, wd;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_prio[i] = 0; m_pend[i] = 0; m_infl[i] = 0; m_en[0][i] = 0; m_en[1][i] = 0;
         end
         m_thr[0] = 0; m_thr[1] = 0;
         e_meip = 0; e_seip = 0; e_res = '0;
      end else begin
         b0 = m_best(0);
         b1 = m_best(1);
         e_meip = (b0 != 0);
         e_seip = (b1 != 0);
         off = req_in.paddr - BASE;
         wd  = req_in.data;
         np = m_pend;
         ni = m_infl;
         for (int i = 1; i < N; i++) if (src_irq[i] && !m_infl[i]) np[i] = 1;
         e_res = '0;
         if (req_in.valid && !req_in.is_write) begin
            e_res = '{valid: 1'b1, id: req_in.id, data: m_read(off, b0, b1)};
            if (off == 32'h20_0004 && b0 != 0) begin np[b0] = 0; ni[b0] = 1; end
            if (off == 32'h20_1004 && b1 != 0) begin np[b1] = 0; ni[b1] = 1; end
         end
         if (req_in.valid && req_in.is_write) begin
            c = (off == 32'h2080 || off == 32'h20_1000) ? 1 : 0;
            if (off[1:0] == 2'b00 && off >= 32'd4 && off < 32'(4 * N)) m_prio[off >> 2] = int'(wd[2:0]);
            if (off == 32'h2000 || off == 32'h2080)
               for (int i = 0; i < N; i++) m_en[c][i] = (i != 0) && wd[i];
            if (off == 32'h20_0000 || off == 32'h20_1000) m_thr[c] = int'(wd[2:0]);
            if ((off == 32'h20_0004 || off == 32'h20_1004) && wd >= 1 && wd < N && m_infl[wd]) ni[wd] = 0;
         end
         m_pend = np;
         m_infl = ni;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("meip", 64'(meip), 64'(e_meip));
         check("seip", 64'(seip), 64'(e_seip));
         check("res_out", 64'(res_out), 64'(e_res));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      req_in = '{valid: 1'b1, id: 8'h00, paddr: BASE + off, is_write: 1'b1, data: d};
      idle(1);
      req_in = '0;
   endtask

   task automatic rd(input logic [31:0] off, input logic [7:0] id, output logic [31:0] d);
      req_in = '{valid: 1'b1, id: id, paddr: BASE + off, is_write: 1'b0, data: 32'h0};
      idle(1);
      req_in = '0;
      d = res_out.data;
      check("rd_valid", 64'(res_out.valid), 64'd1);
      check("rd_id", 64'(res_out.id), 64'(id));
   endtask

   task automatic do_reset;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [31:0] d;
   logic [31:0] raddr [10];

   initial begin
      req_in  = '0;
      src_irq = '0;
      reset   = 1'b1;
      idle(2);
      chk_en = 1;
      check("rst_meip", 64'(meip), 64'd0);
      check("rst_seip", 64'(seip), 64'd0);
      check("rst_res_valid", 64'(res_out.valid), 64'd0);
      reset = 1'b0;
      raddr = '{32'd4, 32'd40, 32'd92, 32'h1000, 32'h2000, 32'h2080,
                32'h20_0000, 32'h20_0004, 32'h20_1000, 32'h20_1004};
      foreach (raddr[k]) begin
         rd(raddr[k], 8'(k), d);
         check("rst_reg", 64'(d), 64'd0);
      end

      // basic claim/complete on source 10
      wr(40, 1); wr(32'h2000, 32'h400); wr(32'h20_0000, 0);
      src_irq[10] = 1'b1;
      idle(1); check("basic_meip_e1", 64'(meip), 64'd0);
      idle(1); check("basic_meip_e2", 64'(meip), 64'd1);
      rd(32'h20_0004, 8'h03, d); check("basic_claim", 64'(d), 64'd10);
      idle(1); check("basic_meip_after_claim", 64'(meip), 64'd0);
      wr(32'h20_0004, 10);
      idle(1); check("recomplete_meip_e1", 64'(meip), 64'd0);
      idle(1); check("recomplete_meip_e2", 64'(meip), 64'd1);
      src_irq[10] = 1'b0;
      rd(32'h20_0004, 8'h04, d); check("basic_claim2", 64'(d), 64'd10);
      wr(32'h20_0004, 10);
      idle(2); check("basic_quiet", 64'(meip), 64'd0);

      // priority, tie-break, threshold
      do_reset;
      wr(4, 2); wr(8, 2); wr(20, 3); wr(32'h2000, 32'h26);
      src_irq[1] = 1; src_irq[2] = 1; src_irq[5] = 1;
      idle(1); src_irq = '0; idle(2);
      rd(32'h20_0004, 8'h10, d); check("prio_claim_a", 64'(d), 64'd5);
      rd(32'h20_0004, 8'h11, d); check("prio_claim_b", 64'(d), 64'd1);
      rd(32'h20_0004, 8'h12, d); check("prio_claim_c", 64'(d), 64'd2);
      rd(32'h20_0004, 8'h13, d); check("prio_claim_d", 64'(d), 64'd0);
      wr(32'h20_0004, 5); wr(32'h20_0004, 1); wr(32'h20_0004, 2);
      wr(32'h20_0000, 3);
      src_irq[1] = 1; src_irq[2] = 1; src_irq[5] = 1;
      idle(1); src_irq = '0; idle(2);
      check("thr_meip", 64'(meip), 64'd0);
      rd(32'h20_0004, 8'h14, d); check("thr_claim", 64'(d), 64'd0);
      idle(2); check("thr_meip2", 64'(meip), 64'd0);

      // two contexts
      do_reset;
      wr(40, 1); wr(32'h2080, 32'h400);
      src_irq[10] = 1'b1;
      idle(2);
      check("ctx_seip", 64'(seip), 64'd1);
      check("ctx_meip", 64'(meip), 64'd0);
      rd(32'h20_1004, 8'h20, d); check("ctx1_claim", 64'(d), 64'd10);
      rd(32'h20_0004, 8'h21, d); check("ctx0_claim", 64'(d), 64'd0);

      // edge cases: bad completes, pending write, invalid read, enable bit 0
      src_irq[10] = 1'b0;
      src_irq[7]  = 1'b1; idle(1); src_irq[7] = 1'b0;
      wr(32'h20_0004, 0); wr(32'h20_1004, N); wr(32'h20_0004, 3);
      wr(32'h1000, 32'hFFFF_FFFF);
      rd(32'h1000, 8'h30, d); check("pend_after_bad", 64'(d), 64'h80);
      rd(32'h3000, 8'h5A, d); check("invalid_rd", 64'(d), 64'd0);
      wr(32'h2000, 32'hFFFF_FFFF);
      rd(32'h2000, 8'h31, d); check("en_mask", 64'(d), 64'h00FF_FFFE);
      wr(32'h20_1004, 10);
      idle(1);
      rd(32'h1000, 8'h32, d); check("pend_after_cmp", 64'(d), 64'h80);

      // reset while a source is in flight
      do_reset;
      wr(40, 1); wr(32'h2000, 32'h400);
      src_irq[10] = 1'b1;
      idle(2);
      rd(32'h20_0004, 8'h40, d); check("rmf_claim1", 64'(d), 64'd10);
      do_reset;
      wr(40, 1); wr(32'h2000, 32'h400);
      idle(2);
      rd(32'h20_0004, 8'h41, d); check("rmf_claim2", 64'(d), 64'd10);
      src_irq = '0;

      // randomized traffic
      do_reset;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r, k, idx;
         logic [31:0] off, dat;
         bit w;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) src_irq[$urandom_range(1, 9)] ^= 1'b1;
         if ($urandom_range(0, 199) == 0) src_irq[$urandom_range(1, N - 1)] ^= 1'b1;
         req_in = '0;
         if (r >= 40) begin
            k   = $urandom_range(0, 11);
            idx = ($urandom_range(0, 19) == 0) ? $urandom_range(N - 1, N) : $urandom_range(0, 9);
            w   = 0;
            dat = $urandom;
            case (k)
               0:  begin off = 32'(4 * idx); w = 1; dat = $urandom_range(0, 7); end
               1:  off = 32'(4 * idx);
               2:  begin off = 32'h2000; w = 1; end
               3:  begin off = 32'h2080; w = 1; end
               4:  begin off = 32'h20_0000; w = 1; dat = $urandom_range(0, 3); end
               5:  begin off = 32'h20_1000; w = 1; dat = $urandom_range(0, 3); end
               6:  off = 32'h20_0004;
               7:  off = 32'h20_1004;
               8:  begin off = 32'h20_0004; w = 1; dat = $urandom_range(0, N + 1); end
               9:  begin off = 32'h20_1004; w = 1; dat = $urandom_range(0, 10); end
               10: begin off = 32'h1000; w = 1'($urandom_range(0, 1)); end
               default: off = ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h20_1000;
            endcase
            req_in = '{valid: 1'b1, id: 8'($urandom), paddr: BASE + off, is_write: w, data: dat};
         end
         if ($urandom_range(0, 399) == 0) reset = 1'b1;
         idle(1);
         reset = 1'b0;
      end
      req_in = '0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
